// File: rtl/prefetch_stream_ctrl_pkg.sv
// rtl/prefetch_stream_ctrl_pkg.sv - shared types and sizing helpers for the prefetch stream controller
package prefetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEMAND   = 2'd1,
    S_PREFETCH = 2'd2
  } pf_state_e;

  localparam int PF_MAX_DEPTH = 8;

  function automatic bit depth_legal(input int depth);
    return (depth >= 1) && (depth <= PF_MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

  // A single-entry buffer still needs a 1-bit pointer to form a legal vector.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_stream_ctrl_if.sv
// rtl/prefetch_stream_ctrl_if.sv - line read channel (request/address, one-cycle ready pulse with data)
interface prefetch_stream_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, output addr, input rdata, input ready);
  modport slave  (input read, input addr, output rdata, output ready);
endinterface

// File: rtl/prefetch_stream_ctrl_pf_line_fifo.sv
// rtl/prefetch_stream_ctrl_pf_line_fifo.sv - circular FIFO of prefetched {address, line} pairs
module pf_line_fifo
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_push   = i_push && !o_full && !i_flush;
  assign w_do_pop    = i_pop && !o_empty && !i_flush;
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries are only meaningful below the occupancy count, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/prefetch_stream_ctrl.sv
// rtl/prefetch_stream_ctrl.sv - I-cache miss proxy with a sequential stream prefetch buffer
// Optional hit/miss counters are built when PREFETCH_STATS_EN is defined.
module prefetch_stream_ctrl
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  prefetch_stream_ctrl_if.slave  i_cache,
  prefetch_stream_ctrl_if.master o_mem,
  input  logic                   i_pf_flush
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]            o_stat_hits,
  output logic [31:0]            o_stat_misses
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  if (!depth_legal(DEPTH)) begin : g_depth_err
    $error("prefetch_stream_ctrl: DEPTH must be a power of two in 1..8");
  end

  pf_state_e         r_state;
  logic              r_cache_ready;
  logic [DATA_W-1:0] r_cache_rdata;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_pf_next;
  logic              r_pf_next_valid;
  logic              r_flush_seen;

  logic              w_idle;
  logic              w_req;
  logic              w_hit;
  logic              w_miss;
  logic              w_pf_issue;
  logic              w_push;
  logic              w_fifo_flush;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // The cache drops its request on the edge after ready, so the ready cycle sees no request.
  assign w_idle       = (r_state == S_IDLE);
  assign w_req        = i_cache.read && !r_cache_ready;
  assign w_hit        = w_idle && w_req && !i_pf_flush && !w_empty && (w_head_addr == i_cache.addr);
  assign w_miss       = w_idle && w_req && !w_hit;
  assign w_pf_issue   = w_idle && !w_req && !i_pf_flush && !w_full && r_pf_next_valid;
  assign w_push       = (r_state == S_PREFETCH) && o_mem.ready && !r_flush_seen && !i_pf_flush;
  assign w_fifo_flush = i_pf_flush || w_miss;

  pf_line_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (r_mem_addr),
    .i_push_data (o_mem.rdata),
    .i_pop       (w_hit),
    .i_flush     (w_fifo_flush),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cache_ready   <= 1'b0;
      r_cache_rdata   <= '0;
      r_mem_read      <= 1'b0;
      r_mem_addr      <= '0;
      r_pf_next       <= '0;
      r_pf_next_valid <= 1'b0;
      r_flush_seen    <= 1'b0;
    end else begin
      r_cache_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_pf_flush) r_pf_next_valid <= 1'b0;
          if (w_hit) begin
            r_cache_rdata <= w_head_data;
            r_cache_ready <= 1'b1;
          end else if (w_miss) begin
            r_mem_read   <= 1'b1;
            r_mem_addr   <= i_cache.addr;
            r_flush_seen <= 1'b0;
            r_state      <= S_DEMAND;
          end else if (w_pf_issue) begin
            r_mem_read   <= 1'b1;
            r_mem_addr   <= r_pf_next;
            r_flush_seen <= 1'b0;
            r_state      <= S_PREFETCH;
          end
        end
        S_DEMAND: begin
          if (i_pf_flush) r_flush_seen <= 1'b1;
          if (o_mem.ready) begin
            r_cache_rdata   <= o_mem.rdata;
            r_cache_ready   <= 1'b1;
            r_mem_read      <= 1'b0;
            r_pf_next       <= r_mem_addr + ADDR_ONE;
            r_pf_next_valid <= !(&r_mem_addr) && !r_flush_seen && !i_pf_flush;
            r_state         <= S_IDLE;
          end
        end
        S_PREFETCH: begin
          if (i_pf_flush) begin
            r_flush_seen    <= 1'b1;
            r_pf_next_valid <= 1'b0;
          end
          if (o_mem.ready) begin
            r_mem_read <= 1'b0;
            r_state    <= S_IDLE;
            if (!r_flush_seen && !i_pf_flush) begin
              r_pf_next <= r_pf_next + ADDR_ONE;
              if (&r_pf_next) r_pf_next_valid <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_cache.ready = r_cache_ready;
  assign i_cache.rdata = r_cache_rdata;
  assign o_mem.read    = r_mem_read;
  assign o_mem.addr    = r_mem_addr;

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else begin
      if (w_hit && (r_stat_hits != '1))    r_stat_hits   <= r_stat_hits + 32'd1;
      if (w_miss && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 32'd1;
    end
  end

  assign o_stat_hits   = r_stat_hits;
  assign o_stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_prefetch_stream_ctrl.sv
// tb/tb_prefetch_stream_ctrl.sv - self-checking bench for prefetch_stream_ctrl
module tb_prefetch_stream_ctrl;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] AMAX = 28'hFFFFFFF;

  logic clk;
  logic rst;
  logic pf_flush;

  prefetch_stream_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();
  prefetch_stream_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  prefetch_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cache    (cif),
    .o_mem      (mif),
    .i_pf_flush (pf_flush)
`ifdef PREFETCH_STATS_EN
    ,
    .o_stat_hits   (stat_hits),
    .o_stat_misses (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // memory responder state
  int                mem_lat  = 5;
  int                mem_cnt  = 0;
  bit                mem_busy = 0;
  bit                mem_rdy  = 0;
  logic [ADDR_W-1:0] mem_cur  = '0;
  logic [DATA_W-1:0] mem_dat  = '0;
  int                nreads   = 0;
  int                land_cyc = 0;
  logic [ADDR_W-1:0] rd_log[$];

  // reference model of the stream buffer at quiescence
  logic [ADDR_W-1:0] mq[$];
  logic [ADDR_W-1:0] m_next;
  bit                m_nv;

  typedef struct {
    int                kind;  // 0 request, 1 flush, 2 request with coincident flush
    logic [ADDR_W-1:0] addr;
    bit                exp_hit;
    int                exp_reads;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [DATA_W-1:0] fdat(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {4'h0, a};
    return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd7};
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mem_rdy  = 0;
      mem_busy = 0;
    end else if (mem_rdy) begin
      mem_rdy  = 0;
      mem_busy = 0;
      land_cyc = cyc;
      chk("mem_read_drop", mif.read, 1'b0);
    end else if (mif.read) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_cnt  = mem_lat;
        mem_cur  = mif.addr;
        nreads++;
        rd_log.push_back(mif.addr);
      end else begin
        chk("mem_addr_stable", mif.addr, mem_cur);
      end
      if (mem_cnt <= 1) begin
        mem_rdy = 1;
        mem_dat = fdat(mem_cur);
      end else begin
        mem_cnt--;
      end
    end
    mif.ready = mem_rdy;
    mif.rdata = mem_rdy ? mem_dat : '0;
  endtask

  task automatic settle();
    int idle = 0;
    int n    = 0;
    while (idle < 4 && n < 400) begin
      tick();
      n++;
      if (mif.read || mem_rdy) idle = 0;
      else idle++;
    end
    if (n >= 400) chk("settle_timeout", 1'b1, 1'b0);
  endtask

  task automatic req_resp(input logic [ADDR_W-1:0] a, input bit with_flush, output int k, output bit hit);
    int r0 = nreads;
    cif.read = 1'b1;
    cif.addr = a;
    pf_flush = with_flush;
    k = 0;
    hit = 0;
    do begin
      tick();
      pf_flush = 1'b0;
      k++;
    end while (!cif.ready && k < 64);
    chk("resp_seen", cif.ready, 1'b1);
    chk("resp_data", cif.rdata, fdat(a));
    hit = (nreads == r0);
    cif.read = 1'b0;
  endtask

  task automatic apply_op(input int kind, input logic [ADDR_W-1:0] a, output bit hit, output int reads, output int k);
    int r0 = nreads;
    hit = 0;
    k   = 0;
    if (kind == 1) begin
      pf_flush = 1'b1;
      tick();
      pf_flush = 1'b0;
    end else begin
      req_resp(a, kind == 2, k, hit);
    end
    settle();
    reads = nreads - r0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    m_nv   = 0;
    m_next = '0;
  endtask

  function automatic int model_fill();
    int n = 0;
    while (mq.size() < DEPTH && m_nv) begin
      mq.push_back(m_next);
      n++;
      if (m_next == AMAX) m_nv = 0;
      else m_next = m_next + 1;
    end
    return n;
  endfunction

  task automatic model_op(input int kind, input logic [ADDR_W-1:0] a, output bit hit, output int reads);
    hit = 0;
    if (kind != 0) begin
      mq.delete();
      m_nv = 0;
    end
    if (kind == 1) begin
      reads = 0;
    end else if (mq.size() > 0 && mq[0] == a) begin
      hit = 1;
      void'(mq.pop_front());
      reads = model_fill();
    end else begin
      mq.delete();
      m_nv   = (a != AMAX);
      m_next = a + 1;
      reads  = 1 + model_fill();
    end
  endtask

  function automatic int count_reads(input logic [ADDR_W-1:0] a);
    int c = 0;
    foreach (rd_log[i]) if (rd_log[i] == a) c++;
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit                hit;
    int                reads;
    int                k;
    int                n;
    int                r0;
    bit                ehit;
    int                ereads;
    int                kind;
    int                r;
    logic [ADDR_W-1:0] a;

    tbl[0]  = '{0, 28'h0000100, 1'b0, 5};
    tbl[1]  = '{0, 28'h0000101, 1'b1, 1};
    tbl[2]  = '{0, 28'h0000102, 1'b1, 1};
    tbl[3]  = '{0, 28'h0000200, 1'b0, 5};
    tbl[4]  = '{1, 28'h0000000, 1'b0, 0};
    tbl[5]  = '{0, 28'h0000201, 1'b0, 5};
    tbl[6]  = '{0, 28'h0000202, 1'b1, 1};
    tbl[7]  = '{0, 28'h0000204, 1'b0, 5};
    tbl[8]  = '{2, 28'h0000205, 1'b0, 5};
    tbl[9]  = '{0, 28'hFFFFFFF, 1'b0, 1};
    tbl[10] = '{0, 28'hFFFFFFD, 1'b0, 3};
    tbl[11] = '{0, 28'hFFFFFFE, 1'b1, 0};
    tbl[12] = '{0, 28'hFFFFFFF, 1'b1, 0};
    tbl[13] = '{0, 28'hFFFFFFF, 1'b0, 1};

    rst       = 1'b1;
    pf_flush  = 1'b0;
    cif.read  = 1'b0;
    cif.addr  = '0;
    mif.ready = 1'b0;
    mif.rdata = '0;
    tick();
    tick();
    chk("rst_cache_ready", cif.ready, 1'b0);
    chk("rst_cache_rdata", cif.rdata, '0);
    chk("rst_mem_read", mif.read, 1'b0);
    chk("rst_mem_addr", mif.addr, '0);
    do_reset();

    // directed table, memory latency 5
    mem_lat = 5;
    for (int i = 0; i < 14; i++) begin
      apply_op(tbl[i].kind, tbl[i].addr, hit, reads, k);
      if (tbl[i].kind != 1) begin
        chk($sformatf("tbl%0d_hit", i), hit, tbl[i].exp_hit);
        chk($sformatf("tbl%0d_latency", i), k, tbl[i].exp_hit ? 1 : 1 + mem_lat);
      end
      chk($sformatf("tbl%0d_mem_reads", i), reads, tbl[i].exp_reads);
    end

    // request for the line whose prefetch is in flight waits, then hits
    do_reset();
    rd_log.delete();
    req_resp(28'h0000100, 1'b0, k, hit);
    req_resp(28'h0000101, 1'b0, k, hit);
    chk("inflight_hit_timing", cyc, land_cyc + 1);
    settle();
    chk("inflight_single_read", count_reads(28'h0000101), 1);

    // flush while a prefetch is outstanding discards that line
    do_reset();
    mem_lat = 6;
    req_resp(28'h0000100, 1'b0, k, hit);
    n = 0;
    while (!(mem_busy && mem_cur == 28'h0000101) && n < 50) begin tick(); n++; end
    chk("pf_outstanding_seen", mem_cur, 28'h0000101);
    r0 = nreads;
    pf_flush = 1'b1;
    tick();
    pf_flush = 1'b0;
    settle();
    chk("flush_no_more_pf", nreads - r0, 0);
    apply_op(0, 28'h0000101, hit, reads, k);
    chk("flushed_line_misses", hit, 1'b0);
    chk("flushed_line_reads", reads, 5);

    // reset with a prefetch outstanding
    do_reset();
    req_resp(28'h0000300, 1'b0, k, hit);
    n = 0;
    while (!(mem_busy && mem_cur == 28'h0000301) && n < 50) begin tick(); n++; end
    rst = 1'b1;
    tick();
    chk("rst_mid_mem_read", mif.read, 1'b0);
    chk("rst_mid_cache_ready", cif.ready, 1'b0);
    rst = 1'b0;
    mq.delete();
    m_nv = 0;
    r0 = nreads;
    settle();
    chk("rst_mid_no_pf", nreads - r0, 0);
    apply_op(0, 28'h0000301, hit, reads, k);
    chk("rst_mid_buffer_empty", hit, 1'b0);
    chk("rst_mid_refetch_reads", reads, 5);

    // randomized operations against the quiescent-state model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(1, 6);
      r = $urandom_range(0, 99);
      kind = (r < 12) ? 1 : (r < 20) ? 2 : 0;
      r = $urandom_range(0, 99);
      if (r < 50 && mq.size() > 0) a = mq[0];
      else if (r < 65 && mq.size() > 0) a = mq[0] + 1;
      else if (r < 80) a = AMAX - 28'($urandom_range(0, 5));
      else a = 28'($urandom());
      model_op(kind, a, ehit, ereads);
      apply_op(kind, a, hit, reads, k);
      if (kind != 1) begin
        chk($sformatf("rnd%0d_hit", i), hit, ehit);
        chk($sformatf("rnd%0d_latency", i), k, ehit ? 1 : 1 + mem_lat);
      end
      chk($sformatf("rnd%0d_mem_reads", i), reads, ereads);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prefetch_stream_ctrl.md
# prefetch_stream_ctrl

Parametrised successor to the single-line cache/memory read proxy: sits between the I-cache miss port and the main-memory port. It adds a DEPTH-entry sequential stream buffer that holds prefetched consecutive lines. Requests that hit the buffer head are served in one cycle without touching memory. Misses fall through to a demand fetch, after which the buffer refills with the following lines.

## Interface
- ADDR_W, 28, line address width
- DATA_W, 128, line width in bits
- DEPTH, 4, stream buffer entries; power of two, 1..8
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cache_mem_read  in  1  cache read request, held until cache_mem_ready
- cache_mem_addr  in  ADDR_W  requested line address, stable while read high
- cache_mem_rdata  out  DATA_W  returned line, valid when cache_mem_ready
- cache_mem_ready  out  1  one-cycle response pulse
- pf_flush  in  1  invalidate stream buffer (branch/fence)
- mem_read  out  1  memory read request, held until mem_ready
- mem_addr  out  ADDR_W  memory line address
- mem_ready  in  1  one-cycle memory data-valid pulse
- mem_rdata  in  DATA_W  memory line data

## Operation
- All outputs are registered. Reset values: all 0. Buffer is empty at reset.
- FSM states:
  - S_IDLE
  - S_DEMAND: demand fetch outstanding
  - S_PREFETCH: prefetch outstanding
- S_IDLE priority, highest first:
  - pf_flush: invalidate every entry and clear pf_next_valid.
  - Request present and buffer head valid with head address == cache_mem_addr: hit. Pop head, drive its data, pulse cache_mem_ready.
  - Request present otherwise: miss. Invalidate every entry, go to S_DEMAND.
  - No request, buffer not full, pf_next_valid: go to S_PREFETCH at pf_next.
- S_DEMAND:
  - On mem_ready: capture mem_rdata, pulse cache_mem_ready, set pf_next = addr+1, set pf_next_valid, return to S_IDLE.
- S_PREFETCH:
  - On mem_ready: push {pf_next, mem_rdata} at the tail, advance pf_next, return to S_IDLE.
  - If pf_flush was seen while outstanding, discard the data and do not push.
- Wrap rule: when a fetched address is all-ones, clear pf_next_valid. Prefetch never wraps to 0.
- cache_mem_read is ignored in the cycle cache_mem_ready is high, because the cache drops the request on the following edge.
- A request arriving during S_PREFETCH waits. The outstanding memory transaction cannot be aborted. The request is evaluated in S_IDLE after the prefetch lands, so a request for the line being prefetched hits.
- pf_flush during S_DEMAND does not affect the demand response. It only blocks the subsequent pf_next_valid.
- pf_flush coincident with a request in S_IDLE: flush first, then the request is treated as a miss.

## Timing
- Hit: request sampled in S_IDLE at cycle T, cache_mem_ready and rdata at T+1.
- Miss: mem_read and mem_addr high at T+1. mem_ready at cycle M gives cache_mem_ready at M+1, and mem_read is low at M+1.
- Prefetch issue: the first S_IDLE cycle with no request and a free entry; mem_read goes high the next cycle.
- mem_addr is stable for the whole time mem_read is high.
- No back-to-back memory requests: mem_read is low for at least one cycle between transactions.
- cache_mem_rdata holds its last value until the next response.
- rst at any time, including with a transaction outstanding, returns the block to S_IDLE with an empty buffer and mem_read low the next cycle. Memory shares rst.

## Configuration
- PREFETCH_STATS_EN defined: adds outputs stat_hits (32) and stat_misses (32).
  - Saturating counters, cleared by rst.
  - Incremented in the cycle a hit or miss is decided.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package prefetch_pkg holds:
  - the state enum (S_IDLE, S_DEMAND, S_PREFETCH)
  - the DEPTH legality check
  - the pointer-width localparam $clog2(DEPTH)
- Sub-module pf_line_fifo: DEPTH x (ADDR_W+DATA_W) circular FIFO.
  - Provides push, pop, flush, full, empty, head_addr and head_data.
  - Occupancy counter is $clog2(DEPTH)+1 bits.

## Test plan
- Cold miss at 0x100, memory latency 5: mem_read at T+1, cache_mem_ready at M+1 with the memory data. Then four prefetches at 0x101–0x104 fill the buffer.
- Sequential reads 0x101, 0x102 after fill: each gets cache_mem_ready one cycle after request, with no mem_read. Refill of 0x105 and 0x106 follows.
- Non-sequential read 0x200 with the buffer full: miss, buffer invalidated, demand fetch 0x200, then prefetch from 0x201.
- Request 0x101 while the 0x101 prefetch is outstanding: waits, then hits one cycle after S_IDLE is re-entered. Only one memory read of 0x101 occurs.
- pf_flush during an outstanding prefetch: the returned line is discarded, and the next request to that address misses.
- Demand fetch at 0xFFFFFFF: response correct, no prefetch issued. rst mid-prefetch: mem_read low and buffer empty next cycle.
